clk_div_prog: RTL



---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_shadow.sv | 39 +++
 rtl/clk_div_prog.sv | 78 +++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider and its users.
// Standard divisors assume the 50 MHz system clock.
package clk_div_pkg;

  localparam int unsigned DEF_CNT_W = 26;
  localparam int unsigned DIV_MIN   = 2;

  localparam int unsigned DIV_1HZ   = 50_000_000;
  localparam int unsigned DIV_100HZ = 500_000;
  localparam int unsigned DIV_1KHZ  = 50_000;

endpackage

// File: rtl/clk_div_shadow.sv
// Shadow divisor register: validates runtime loads and holds them until the
// counter core consumes the pending value on a wrap or a clear.
module clk_div_shadow
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DIV_DEFAULT = DIV_100HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  input  logic             wrap,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             pending,
  output logic             err,
  output logic             load_ok_c
);

  assign load_ok_c = div_load && (div_in >= CNT_W'(DIV_MIN));

  // A load on the consuming edge wins over the consume, except for clr,
  // which applies that load directly to the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value   <= CNT_W'(DIV_DEFAULT);
      pending <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= div_load && !load_ok_c;
      if (load_ok_c) value <= div_in;
      if (clr)            pending <= 1'b0;
      else if (load_ok_c) pending <= 1'b1;
      else if (wrap)      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: one-cycle tick and square-wave clk_out at clk/N,
// with divisor changes deferred to period boundaries so the output never glitches.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DIV_DEFAULT = DIV_100HZ
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             tick,
  output logic             clk_out,
  output logic [CNT_W-1:0] div_cur,
  output logic             div_pending,
  output logic             div_err
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] hi;
  logic [CNT_W-1:0] sh_value;
  logic             sh_load_ok;
  logic             wrap;
  logic             fall;

  assign limit = div_cur - CNT_W'(1);
  assign hi    = div_cur - (div_cur >> 1);
  assign wrap  = en && (cnt == limit);
  assign fall  = en && (cnt == hi - CNT_W'(1));

  clk_div_shadow #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_shadow (
    .clk       (clk_50MHz),
    .rst       (rst),
    .div_in    (div_in),
    .div_load  (div_load),
    .wrap      (wrap),
    .clr       (clr),
    .value     (sh_value),
    .pending   (div_pending),
    .err       (div_err),
    .load_ok_c (sh_load_ok)
  );

  // Counter core: clr restarts the period, wrap starts a new high phase.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      div_cur <= CNT_W'(DIV_DEFAULT);
    end else if (clr) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      if (sh_load_ok)       div_cur <= div_in;
      else if (div_pending) div_cur <= sh_value;
    end else if (wrap) begin
      cnt     <= '0;
      tick    <= 1'b1;
      clk_out <= 1'b1;
      if (div_pending) div_cur <= sh_value;
    end else if (en) begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
      if (fall) clk_out <= 1'b0;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule
